// File: rtl/mmio_peripheral_bus_pkg.sv
// Shared definitions for the MMIO peripheral responder: register byte offsets
// within the 32-byte window, TCON bit positions and the default window base.
package mmio_peripheral_bus_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  // Word-aligned byte offsets inside the peripheral window.
  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LED     = 5'h0C;
  localparam logic [4:0] OFF_DIGITS  = 5'h10;
  localparam logic [4:0] OFF_SYSTICK = 5'h14;

  // TCON bit indices.
  localparam int unsigned TCON_EN    = 0;
  localparam int unsigned TCON_IRQEN = 1;
  localparam int unsigned TCON_IRQ   = 2;

endpackage

// File: rtl/mmio_peripheral_bus_timer.sv
// periph_timer: reloadable up-counting timer with sticky interrupt flag.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   th_we_i, tl_we_i,
//   tcon_we_i           CPU write strobes for TH, TL and TCON
//   wdata_i             CPU store data
//   th_o, tl_o, tcon_o  current register contents for the read mux
//   irq_o               interrupt request (TCON irq_status bit)
module periph_timer
  import mmio_peripheral_bus_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        th_we_i,
  input  logic        tl_we_i,
  input  logic        tcon_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output logic [2:0]  tcon_o,
  output logic        irq_o
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        at_max;
  logic        irq_set;

  assign at_max = (tl_q == 32'hFFFF_FFFF);
  // A CPU write to TL pre-empts the reload, so no overflow is flagged then.
  assign irq_set = tcon_q[TCON_EN] && at_max && tcon_q[TCON_IRQEN] && !tl_we_i;

  always_comb begin
    th_d = th_we_i ? wdata_i : th_q;

    tl_d = tl_q;
    if (tl_we_i) begin
      tl_d = wdata_i;
    end else if (tcon_q[TCON_EN]) begin
      // Reload uses the pre-write TH even if TH is written this cycle.
      tl_d = at_max ? th_q : tl_q + 32'd1;
    end

    tcon_d = tcon_q;
    if (tcon_we_i) begin
      tcon_d = wdata_i[2:0];
    end
    // A pending overflow is ORed in so a concurrent TCON write cannot drop it.
    tcon_d[TCON_IRQ] = tcon_d[TCON_IRQ] | irq_set;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = tcon_q;
  assign irq_o  = tcon_q[TCON_IRQ];

endmodule

// File: rtl/mmio_peripheral_bus.sv
// mmio_peripheral_bus: memory-mapped peripheral responder on the CPU data bus.
// Answers a 32-byte window at BASE_ADDR holding a reloadable timer, an LED
// register, a 7-segment digit register and a free-running SYSTICK counter.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   Address           CPU byte address (bits [1:0] ignored)
//   Write_data        CPU store data
//   MemRead/MemWrite  CPU read and write strobes
//   Read_data         combinational read data (0 on miss or no read)
//   leds              LED register
//   digits            {AN[3:0], SEG[7:0]} 7-segment register
//   irq               timer interrupt request
module mmio_peripheral_bus
  import mmio_peripheral_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned LED_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Address,
  input  logic [31:0]          Write_data,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  output logic [31:0]          Read_data,
  output logic [LED_WIDTH-1:0] leds,
  output logic [11:0]          digits,
  output logic                 irq
);

  logic                 hit;
  logic [4:0]           offset;
  logic                 we;
  logic [31:0]          rdata;
  logic [LED_WIDTH-1:0] led_q;
  logic [11:0]          digits_q;
  logic [31:0]          systick_q;
  logic [31:0]          th, tl;
  logic [2:0]           tcon;
  logic [1:0]           unused_addr;

  assign unused_addr = Address[1:0];

  assign hit    = (Address[31:5] == BASE_ADDR[31:5]);
  assign offset = {Address[4:2], 2'b00};
  assign we     = MemWrite && hit;

  periph_timer u_timer (
    .clk_i     (clk),
    .rst_i     (reset),
    .th_we_i   (we && (offset == OFF_TH)),
    .tl_we_i   (we && (offset == OFF_TL)),
    .tcon_we_i (we && (offset == OFF_TCON)),
    .wdata_i   (Write_data),
    .th_o      (th),
    .tl_o      (tl),
    .tcon_o    (tcon),
    .irq_o     (irq)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q     <= '0;
      digits_q  <= '0;
      systick_q <= '0;
    end else begin
      if (we && (offset == OFF_LED)) begin
        led_q <= Write_data[LED_WIDTH-1:0];
      end
      if (we && (offset == OFF_DIGITS)) begin
        digits_q <= Write_data[11:0];
      end
      // CPU write has priority over the free-running increment.
      if (we && (offset == OFF_SYSTICK)) begin
        systick_q <= Write_data;
      end else begin
        systick_q <= systick_q + 32'd1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_TH:      rdata = th;
      OFF_TL:      rdata = tl;
      OFF_TCON:    rdata[2:0] = tcon;
      OFF_LED:     rdata[LED_WIDTH-1:0] = led_q;
      OFF_DIGITS:  rdata[11:0] = digits_q;
      OFF_SYSTICK: rdata = systick_q;
      default:     rdata = '0;
    endcase
  end

  assign Read_data = (MemRead && hit) ? rdata : 32'h0;
  assign leds      = led_q;
  assign digits    = digits_q;

endmodule

// File: tb/tb_mmio_peripheral_bus.sv
module tb_mmio_peripheral_bus;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;
  logic [7:0]  leds;
  logic [11:0] digits;
  logic        irq;

  int checks;
  int failures;

  mmio_peripheral_bus #(
    .BASE_ADDR (BASE),
    .LED_WIDTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Read_data  (Read_data),
    .leds       (leds),
    .digits     (digits),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Called shortly after a falling edge; exactly one rising edge commits it.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address    = a;
    Write_data = d;
    MemWrite   = 1'b1;
    MemRead    = 1'b0;
    @(negedge clk);
    MemWrite   = 1'b0;
  endtask

  // Combinational read, no clock edge consumed.
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    Address = a;
    MemRead = 1'b1;
    #1;
    d       = Read_data;
    MemRead = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      rd(BASE + 32'(i * 4), d);
      checks++;
      if (d !== 32'h0) begin
        failures++;
        $display("FAIL reset_read off=%0h got=%h exp=%h", i * 4, d, 32'h0);
      end
    end
    checks++;
    if ({irq, leds, digits} !== 21'h0) begin
      failures++;
      $display("FAIL reset_outputs got irq=%b leds=%h digits=%h exp=0", irq, leds, digits);
    end
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rd(BASE + 32'h14, d);
    checks++;
    if (d !== 32'd2) begin
      failures++;
      $display("FAIL systick_after_reset got=%h exp=%h", d, 32'd2);
    end
  endtask

  task automatic test_timer_overflow;
    logic [31:0] d;
    wr(BASE + 32'h00, 32'hFFFF_FFF0);
    wr(BASE + 32'h04, 32'hFFFF_FFFE);
    wr(BASE + 32'h08, 32'h3);
    @(negedge clk);
    @(negedge clk);
    rd(BASE + 32'h04, d);
    checks++;
    if (d !== 32'hFFFF_FFF0) begin
      failures++;
      $display("FAIL timer_reload got=%h exp=%h", d, 32'hFFFF_FFF0);
    end
    rd(BASE + 32'h08, d);
    checks++;
    if (d !== 32'h7) begin
      failures++;
      $display("FAIL timer_tcon_irq got=%h exp=%h", d, 32'h7);
    end
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL timer_irq got=%b exp=1", irq);
    end
    wr(BASE + 32'h08, 32'h3);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL timer_irq_clear got=%b exp=0", irq);
    end
    rd(BASE + 32'h08, d);
    checks++;
    if (d !== 32'h3) begin
      failures++;
      $display("FAIL timer_tcon_clear got=%h exp=%h", d, 32'h3);
    end
    wr(BASE + 32'h08, 32'h0);
  endtask

  task automatic test_led_digits;
    logic [31:0] d;
    wr(BASE + 32'h0C, 32'h0000_01A5);
    checks++;
    if (leds !== 8'hA5) begin
      failures++;
      $display("FAIL led_out got=%h exp=%h", leds, 8'hA5);
    end
    rd(BASE + 32'h0C, d);
    checks++;
    if (d !== 32'h0000_00A5) begin
      failures++;
      $display("FAIL led_read got=%h exp=%h", d, 32'h0000_00A5);
    end
    wr(BASE + 32'h10, 32'hFFFF_F123);
    rd(BASE + 32'h10, d);
    checks++;
    if (digits !== 12'h123 || d !== 32'h0000_0123) begin
      failures++;
      $display("FAIL digits got out=%h read=%h exp=%h", digits, d, 32'h123);
    end
    wr(BASE + 32'h08, 32'hFFFF_FFF8);
    rd(BASE + 32'h08, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL tcon_upper got=%h exp=%h", d, 32'h0);
    end
  endtask

  task automatic test_miss;
    logic [31:0] d;
    wr(32'h4000_0020, 32'hDEAD_BEEF);
    rd(32'h4000_0020, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL miss_read got=%h exp=%h", d, 32'h0);
    end
    wr(BASE + 32'h18, 32'hDEAD_BEEF);
    rd(BASE + 32'h18, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reserved_read got=%h exp=%h", d, 32'h0);
    end
    rd(BASE + 32'h00, d);
    checks++;
    if (d !== 32'hFFFF_FFF0 || leds !== 8'hA5 || digits !== 12'h123) begin
      failures++;
      $display("FAIL miss_no_change got th=%h leds=%h digits=%h exp th=fffffff0 leds=a5 digits=123",
               d, leds, digits);
    end
    Address = BASE + 32'h14;
    MemRead = 1'b0;
    #1;
    checks++;
    if (Read_data !== 32'h0) begin
      failures++;
      $display("FAIL no_memread got=%h exp=%h", Read_data, 32'h0);
    end
  endtask

  task automatic test_rw_same_cycle;
    Address    = BASE + 32'h0C;
    Write_data = 32'h3C;
    MemRead    = 1'b1;
    MemWrite   = 1'b1;
    #1;
    checks++;
    if (Read_data !== 32'hA5) begin
      failures++;
      $display("FAIL rw_old_value got=%h exp=%h", Read_data, 32'hA5);
    end
    @(negedge clk);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    checks++;
    if (leds !== 8'h3C) begin
      failures++;
      $display("FAIL rw_commit got=%h exp=%h", leds, 8'h3C);
    end
  endtask

  task automatic test_systick;
    logic [31:0] d;
    wr(BASE + 32'h14, 32'd100);
    rd(BASE + 32'h14, d);
    checks++;
    if (d !== 32'd100) begin
      failures++;
      $display("FAIL systick_write got=%h exp=%h", d, 32'd100);
    end
    @(negedge clk);
    rd(BASE + 32'h14, d);
    checks++;
    if (d !== 32'd101) begin
      failures++;
      $display("FAIL systick_inc got=%h exp=%h", d, 32'd101);
    end
    wr(BASE + 32'h14, 32'hFFFF_FFFF);
    @(negedge clk);
    rd(BASE + 32'h14, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL systick_wrap got=%h exp=%h", d, 32'h0);
    end
  endtask

  task automatic test_simultaneous;
    logic [31:0] d;
    wr(BASE + 32'h04, 32'hFFFF_FFFF);
    wr(BASE + 32'h08, 32'h3);
    wr(BASE + 32'h04, 32'h5);
    rd(BASE + 32'h04, d);
    checks++;
    if (d !== 32'h5 || irq !== 1'b0) begin
      failures++;
      $display("FAIL tl_write_wins got tl=%h irq=%b exp tl=5 irq=0", d, irq);
    end
    wr(BASE + 32'h04, 32'hFFFF_FFFE);
    @(negedge clk);
    wr(BASE + 32'h08, 32'h3);
    rd(BASE + 32'h08, d);
    checks++;
    if (d !== 32'h7 || irq !== 1'b1) begin
      failures++;
      $display("FAIL tcon_write_keeps_irq got tcon=%h irq=%b exp tcon=7 irq=1", d, irq);
    end
    rd(BASE + 32'h04, d);
    checks++;
    if (d !== 32'hFFFF_FFF0) begin
      failures++;
      $display("FAIL tcon_overflow_reload got=%h exp=%h", d, 32'hFFFF_FFF0);
    end
    wr(BASE + 32'h04, 32'hFFFF_FFFE);
    @(negedge clk);
    wr(BASE + 32'h00, 32'h0000_1234);
    rd(BASE + 32'h04, d);
    checks++;
    if (d !== 32'hFFFF_FFF0) begin
      failures++;
      $display("FAIL th_write_old_reload got=%h exp=%h", d, 32'hFFFF_FFF0);
    end
    rd(BASE + 32'h00, d);
    checks++;
    if (d !== 32'h0000_1234) begin
      failures++;
      $display("FAIL th_write_commit got=%h exp=%h", d, 32'h0000_1234);
    end
  endtask

  task automatic test_reset_mid_count;
    logic [31:0] d;
    wr(BASE + 32'h04, 32'h100);
    #2;
    reset = 1'b1;
    #1;
    rd(BASE + 32'h04, d);
    checks++;
    if (d !== 32'h0 || irq !== 1'b0 || leds !== 8'h0 || digits !== 12'h0) begin
      failures++;
      $display("FAIL async_reset got tl=%h irq=%b leds=%h digits=%h exp all 0",
               d, irq, leds, digits);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    rd(BASE + 32'h04, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL tl_hold_after_reset got=%h exp=%h", d, 32'h0);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    Address    = '0;
    Write_data = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    test_reset();
    test_timer_overflow();
    test_led_digits();
    test_miss();
    test_rw_same_cycle();
    test_systick();
    test_simultaneous();
    test_reset_mid_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
